// File: rtl/opi_xfer_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | opi_xfer_seq                                                             |
// | Octal-SPI transmit-path transaction sequencer: cmd/addr/dummy/data       |
// | phases into the 32b->8b gearbox, plus chip-select tail and CS-high time. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module opi_xfer_seq #(
    parameter int LEN_W    = 8,
    parameter int DUMMY_W  = 5,
    parameter int TAIL_CYC = 3,
    parameter int CSH_CYC  = 2
) (
    input  logic               clkin50,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [15:0]        req_cmd,
    input  logic [31:0]        req_addr,
    input  logic [LEN_W-1:0]   req_len,
    input  logic [DUMMY_W-1:0] req_dummy,
    input  logic               wdata_valid,
    input  logic [31:0]        wdata,
    output logic               wdata_ready,
    output logic               phy_strobe,
    output logic               phy_lo16b,
    output logic [31:0]        phy_din,
    output logic               cs_n,
    output logic               rx_en,
    output logic               busy,
    output logic               done,
    output logic               err_underrun
);

    // One shared phase counter, wide enough for the 2*len read window,
    // the dummy run and the tail/CS-high intervals.
    localparam int c_w_a   = (LEN_W + 1 > DUMMY_W) ? LEN_W + 1 : DUMMY_W;
    localparam int c_w_b   = ($clog2(TAIL_CYC) > $clog2(CSH_CYC)) ? $clog2(TAIL_CYC) : $clog2(CSH_CYC);
    localparam int c_cnt_w = (c_w_a > c_w_b) ? c_w_a : c_w_b;

    localparam logic [c_cnt_w-1:0] c_tail_last = c_cnt_w'(TAIL_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_csh_last  = c_cnt_w'(CSH_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [LEN_W-1:0]   c_word_one  = LEN_W'(1);

    localparam logic [3:0] c_s_idle  = 4'd0;
    localparam logic [3:0] c_s_cmd   = 4'd1;
    localparam logic [3:0] c_s_gap   = 4'd2;
    localparam logic [3:0] c_s_addr  = 4'd3;
    localparam logic [3:0] c_s_dummy = 4'd4;
    localparam logic [3:0] c_s_wdata = 4'd5;
    localparam logic [3:0] c_s_rdata = 4'd6;
    localparam logic [3:0] c_s_tail  = 4'd7;
    localparam logic [3:0] c_s_csh   = 4'd8;

    logic [3:0]         r_state;
    logic [3:0]         r_gap_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [LEN_W-1:0]   r_words;
    logic               r_rdy_en;
    logic               r_err;
    logic               r_write;
    logic [15:0]        r_cmd;
    logic [31:0]        r_addr;
    logic [LEN_W-1:0]   r_len;
    logic [DUMMY_W-1:0] r_dummy;

    logic [3:0]         w_data_state;
    logic [c_cnt_w-1:0] w_dummy_last;
    logic [c_cnt_w-1:0] w_rd_last;

    assign w_data_state = (r_len == '0) ? c_s_tail : (r_write ? c_s_wdata : c_s_rdata);
    assign w_dummy_last = c_cnt_w'(r_dummy) - c_cnt_one;
    assign w_rd_last    = c_cnt_w'({r_len, 1'b0}) - c_cnt_one;

    always_ff @(posedge clkin50) begin
        if (reset) begin
            r_state    <= c_s_idle;
            r_gap_next <= c_s_idle;
            r_cnt      <= '0;
            r_words    <= '0;
            r_rdy_en   <= 1'b0;
            r_err      <= 1'b0;
            r_write    <= 1'b0;
            r_cmd      <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_dummy    <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            case (r_state)
                c_s_idle: begin
                    if (req_valid && r_rdy_en) begin
                        r_write <= req_write;
                        r_cmd   <= req_cmd;
                        r_addr  <= req_addr;
                        r_len   <= req_len;
                        r_dummy <= req_dummy;
                        r_words <= req_len;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= c_s_cmd;
                    end
                end
                c_s_cmd: begin
                    r_gap_next <= c_s_addr;
                    r_state    <= c_s_gap;
                end
                c_s_addr: begin
                    r_gap_next <= (r_dummy != '0) ? c_s_dummy : w_data_state;
                    r_state    <= c_s_gap;
                end
                c_s_gap: begin
                    r_cnt   <= '0;
                    r_state <= r_gap_next;
                end
                c_s_dummy: begin
                    if (r_cnt == w_dummy_last) begin
                        r_cnt   <= '0;
                        r_state <= w_data_state;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_s_wdata: begin
                    // An empty slot is an underrun: hold the slot open until data shows up.
                    if (wdata_valid) begin
                        r_words    <= r_words - c_word_one;
                        r_gap_next <= (r_words == c_word_one) ? c_s_tail : c_s_wdata;
                        r_state    <= c_s_gap;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                c_s_rdata: begin
                    if (r_cnt == w_rd_last) begin
                        r_cnt   <= '0;
                        r_state <= c_s_tail;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_s_tail: begin
                    if (r_cnt == c_tail_last) begin
                        r_cnt   <= '0;
                        r_state <= c_s_csh;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_s_csh: begin
                    if (r_cnt == c_csh_last) begin
                        r_cnt   <= '0;
                        r_state <= c_s_idle;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= c_s_idle;
                end
            endcase
        end
    end

    // Gearbox controls decode straight from state so the write word and its
    // ready land in the same cycle as wdata_valid.
    always_comb begin
        phy_strobe  = 1'b0;
        phy_lo16b   = 1'b0;
        phy_din     = '0;
        wdata_ready = 1'b0;
        rx_en       = 1'b0;
        case (r_state)
            c_s_cmd: begin
                phy_strobe = 1'b1;
                phy_lo16b  = 1'b1;
                phy_din    = {16'h0000, r_cmd};
            end
            c_s_addr: begin
                phy_strobe = 1'b1;
                phy_din    = {r_addr[15:0], r_addr[31:16]};
            end
            c_s_wdata: begin
                if (wdata_valid) begin
                    phy_strobe  = 1'b1;
                    phy_din     = wdata;
                    wdata_ready = 1'b1;
                end
            end
            c_s_rdata: begin
                rx_en = 1'b1;
            end
            default: begin
                phy_strobe = 1'b0;
            end
        endcase
    end

    assign cs_n         = (r_state == c_s_idle) || (r_state == c_s_csh);
    assign busy         = (r_state != c_s_idle);
    assign req_ready    = (r_state == c_s_idle) && r_rdy_en;
    assign done         = (r_state == c_s_csh) && (r_cnt == '0);
    assign err_underrun = r_err;

endmodule
`default_nettype wire

// File: tb/tb_opi_xfer_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_opi_xfer_seq                                                          |
// | Self-checking bench: per-cycle trace model built from the phase rules.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_opi_xfer_seq;

    localparam int LEN_W    = 8;
    localparam int DUMMY_W  = 5;
    localparam int TAIL_CYC = 3;
    localparam int CSH_CYC  = 2;

    logic               clkin50 = 1'b0;
    logic               reset = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_write = 1'b0;
    logic [15:0]        req_cmd = '0;
    logic [31:0]        req_addr = '0;
    logic [LEN_W-1:0]   req_len = '0;
    logic [DUMMY_W-1:0] req_dummy = '0;
    logic               wdata_valid = 1'b0;
    logic [31:0]        wdata = '0;
    logic               req_ready, wdata_ready, phy_strobe, phy_lo16b;
    logic [31:0]        phy_din;
    logic               cs_n, rx_en, busy, done, err_underrun;

    opi_xfer_seq #(
        .LEN_W(LEN_W), .DUMMY_W(DUMMY_W), .TAIL_CYC(TAIL_CYC), .CSH_CYC(CSH_CYC)
    ) u_dut (
        .clkin50(clkin50), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_cmd(req_cmd), .req_addr(req_addr), .req_len(req_len),
        .req_dummy(req_dummy), .wdata_valid(wdata_valid), .wdata(wdata),
        .wdata_ready(wdata_ready), .phy_strobe(phy_strobe), .phy_lo16b(phy_lo16b),
        .phy_din(phy_din), .cs_n(cs_n), .rx_en(rx_en), .busy(busy), .done(done),
        .err_underrun(err_underrun)
    );

    always #10 clkin50 = ~clkin50;

    int cyc = 0;
    always @(posedge clkin50) cyc <= cyc + 1;

    typedef struct packed {
        logic        rdy;
        logic        busy;
        logic        csn;
        logic        strobe;
        logic        lo16b;
        logic        rx;
        logic        wrdy;
        logic        done;
        logic        err;
        logic [31:0] din;
    } sig_t;

    typedef struct {
        sig_t        e;
        logic        wv;
        logic [31:0] wd;
    } step_t;

    sig_t g_obs [0:4095];
    int   g_len;
    int   g_acc_cyc;
    int   g_done_cyc = 0;
    int   g_prev_done;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic sig_t sample();
        sig_t s;
        s.rdy = req_ready; s.busy = busy; s.csn = cs_n; s.strobe = phy_strobe;
        s.lo16b = phy_lo16b; s.rx = rx_en; s.wrdy = wdata_ready; s.done = done;
        s.err = err_underrun; s.din = phy_din;
        return s;
    endfunction

    // Any cycle between CMD and TAIL with nothing on the bus
    function automatic sig_t active(input logic err);
        sig_t s;
        s = '0;
        s.busy = 1'b1;
        s.err  = err;
        return s;
    endfunction

    function automatic step_t mkstep(input sig_t e, input logic wv, input logic [31:0] wd);
        step_t st;
        st.e = e; st.wv = wv; st.wd = wd;
        return st;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    // Bit k of the result is the selected signal at trace step k.
    function automatic logic [63:0] fmask(input int f);
        logic [63:0] m;
        m = '0;
        for (int k = 0; k < 64 && k <= g_len; k++) begin
            case (f)
                0:       m[k] = g_obs[k].strobe;
                1:       m[k] = g_obs[k].lo16b;
                2:       m[k] = g_obs[k].wrdy;
                3:       m[k] = g_obs[k].rx;
                4:       m[k] = g_obs[k].done;
                default: m[k] = ~g_obs[k].csn;
            endcase
        end
        return m;
    endfunction

    task automatic run_xfer(input bit wr, input logic [15:0] cmd, input logic [31:0] addr,
                            input int len, input int dummy, input int stall_first,
                            input int stall_max, input logic [31:0] w0, input logic [31:0] w1,
                            input bit hold, input int stop_after);
        step_t       q[$];
        sig_t        e;
        logic        errc;
        logic [31:0] wd;
        int          stall;
        int          n;
        int          nf;
        bit          got;
        errc = 1'b0;
        nf   = 0;
        e = active(1'b0); e.strobe = 1'b1; e.lo16b = 1'b1; e.din = {16'h0000, cmd};
        q.push_back(mkstep(e, rbit(), $urandom()));
        q.push_back(mkstep(active(1'b0), rbit(), $urandom()));
        e = active(1'b0); e.strobe = 1'b1; e.din = {addr[15:0], addr[31:16]};
        q.push_back(mkstep(e, rbit(), $urandom()));
        q.push_back(mkstep(active(1'b0), rbit(), $urandom()));
        repeat (dummy) q.push_back(mkstep(active(1'b0), rbit(), $urandom()));
        if (wr) begin
            for (int w = 0; w < len; w++) begin
                if (w == 0 && stall_first >= 0) stall = stall_first;
                else stall = int'($urandom_range(unsigned'(stall_max), 0));
                repeat (stall) begin
                    q.push_back(mkstep(active(errc), 1'b0, $urandom()));
                    errc = 1'b1;
                end
                wd = (w == 0) ? w0 : ((w == 1) ? w1 : $urandom());
                e = active(errc); e.strobe = 1'b1; e.din = wd; e.wrdy = 1'b1;
                q.push_back(mkstep(e, 1'b1, wd));
                q.push_back(mkstep(active(errc), rbit(), $urandom()));
            end
        end else begin
            repeat (2 * len) begin
                e = active(errc); e.rx = 1'b1;
                q.push_back(mkstep(e, rbit(), $urandom()));
            end
        end
        repeat (TAIL_CYC) q.push_back(mkstep(active(errc), rbit(), $urandom()));
        for (int c = 0; c < CSH_CYC; c++) begin
            e = '0; e.busy = 1'b1; e.csn = 1'b1; e.err = errc; e.done = (c == 0);
            q.push_back(mkstep(e, rbit(), $urandom()));
        end
        if (!hold) begin
            e = '0; e.rdy = 1'b1; e.csn = 1'b1; e.err = errc;
            q.push_back(mkstep(e, rbit(), $urandom()));
        end

        g_prev_done = g_done_cyc;
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clkin50);
            if (req_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL accept: req_ready stayed %b, required 1 within 64 cycles", req_ready);
            g_len = 0;
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_cmd   = cmd;
        req_addr  = addr;
        req_len   = LEN_W'(len);
        req_dummy = DUMMY_W'(dummy);
        g_acc_cyc = cyc;
        g_obs[0]  = sample();
        n = q.size();
        g_len = 0;
        for (int k = 1; k <= n; k++) begin
            if (stop_after >= 0 && k > stop_after) break;
            @(posedge clkin50);
            #1;
            wdata_valid = q[k-1].wv;
            wdata       = q[k-1].wd;
            if (!hold) begin
                req_valid = 1'b0;
            end else begin
                req_write = rbit();
                req_cmd   = 16'($urandom());
                req_addr  = $urandom();
                req_len   = LEN_W'($urandom());
                req_dummy = DUMMY_W'($urandom());
            end
            @(negedge clkin50);
            g_obs[k] = sample();
            g_len    = k;
            if (g_obs[k].done === 1'b1) g_done_cyc = cyc;
            n_checks++;
            if (g_obs[k] !== q[k-1].e) begin
                n_errors++;
                if (nf < 8) $display("FAIL trace step %0d: got %h required %h", k, g_obs[k], q[k-1].e);
                nf++;
            end
        end
        wdata_valid = 1'b0;
    endtask

    task automatic test_reset();
        sig_t e;
        reset = 1'b1;
        req_valid = 1'b0;
        wdata_valid = 1'b1;
        repeat (3) @(negedge clkin50);
        e = '0; e.csn = 1'b1;
        n_checks++;
        if (sample() !== e) begin
            n_errors++;
            $display("FAIL reset_state: got %h required %h", sample(), e);
        end
        @(posedge clkin50);
        #1;
        reset = 1'b0;
        wdata_valid = 1'b0;
        @(negedge clkin50);
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release_ready: got %b required 0", req_ready);
        end
        @(negedge clkin50);
        e.rdy = 1'b1;
        n_checks++;
        if (sample() !== e) begin
            n_errors++;
            $display("FAIL reset_idle: got %h required %h", sample(), e);
        end
    endtask

    task automatic test_write_basic();
        run_xfer(1'b1, 16'h12ED, 32'h0000_1000, 2, 0, 0, 0, 32'hAABBCCDD, 32'h11223344, 1'b0, -1);
        n_checks++;
        if (fmask(0) !== 64'h0AA) begin n_errors++; $display("FAIL wr_strobes: got %h required %h", fmask(0), 64'h0AA); end
        n_checks++;
        if (fmask(1) !== 64'h002) begin n_errors++; $display("FAIL wr_lo16b: got %h required %h", fmask(1), 64'h002); end
        n_checks++;
        if (g_obs[3].din !== 32'h1000_0000) begin n_errors++; $display("FAIL wr_addr_din: got %h required 10000000", g_obs[3].din); end
        n_checks++;
        if (g_obs[5].din !== 32'hAABBCCDD || g_obs[7].din !== 32'h11223344) begin
            n_errors++; $display("FAIL wr_data_din: got %h %h required aabbccdd 11223344", g_obs[5].din, g_obs[7].din);
        end
        n_checks++;
        if (fmask(2) !== 64'h0A0) begin n_errors++; $display("FAIL wr_wready: got %h required %h", fmask(2), 64'h0A0); end
        n_checks++;
        if (fmask(5) !== 64'hFFE) begin n_errors++; $display("FAIL wr_csn_low: got %h required %h", fmask(5), 64'hFFE); end
        n_checks++;
        if (fmask(4) !== 64'h1000) begin n_errors++; $display("FAIL wr_done: got %h required %h", fmask(4), 64'h1000); end
        n_checks++;
        if (g_obs[13].rdy !== 1'b0 || g_obs[14].rdy !== 1'b1) begin
            n_errors++; $display("FAIL wr_ready_return: got %b%b required 01", g_obs[13].rdy, g_obs[14].rdy);
        end
    endtask

    task automatic test_read_dummy();
        run_xfer(1'b0, 16'h0B0B, $urandom(), 1, 4, 0, 0, 32'h0, 32'h0, 1'b0, -1);
        n_checks++;
        if (fmask(0) !== 64'h00A) begin n_errors++; $display("FAIL rd_strobes: got %h required %h", fmask(0), 64'h00A); end
        n_checks++;
        if (fmask(3) !== 64'h600) begin n_errors++; $display("FAIL rd_rx_window: got %h required %h", fmask(3), 64'h600); end
        n_checks++;
        if (fmask(5) !== 64'h3FFE) begin n_errors++; $display("FAIL rd_csn_low: got %h required %h", fmask(5), 64'h3FFE); end
        n_checks++;
        if (fmask(4) !== 64'h4000) begin n_errors++; $display("FAIL rd_done: got %h required %h", fmask(4), 64'h4000); end
    endtask

    task automatic test_underrun();
        run_xfer(1'b1, 16'h0202, $urandom(), 1, 0, 3, 0, 32'hCAFE_F00D, 32'h0, 1'b0, -1);
        n_checks++;
        if (fmask(0) !== 64'h10A) begin n_errors++; $display("FAIL ur_strobes: got %h required %h", fmask(0), 64'h10A); end
        n_checks++;
        if (fmask(2) !== 64'h100) begin n_errors++; $display("FAIL ur_wready: got %h required %h", fmask(2), 64'h100); end
        n_checks++;
        if ({g_obs[5].err, g_obs[6].err, g_obs[13].err, g_obs[15].err} !== 4'b0111) begin
            n_errors++;
            $display("FAIL ur_err_sticky: got %b%b%b%b required 0111", g_obs[5].err, g_obs[6].err, g_obs[13].err, g_obs[15].err);
        end
    endtask

    task automatic test_read_nodata();
        run_xfer(1'b0, 16'h0303, $urandom(), 0, 0, 0, 0, 32'h0, 32'h0, 1'b0, -1);
        n_checks++;
        if (fmask(0) !== 64'h00A) begin n_errors++; $display("FAIL nd_strobes: got %h required %h", fmask(0), 64'h00A); end
        n_checks++;
        if (fmask(5) !== 64'h0FE) begin n_errors++; $display("FAIL nd_csn_low: got %h required %h", fmask(5), 64'h0FE); end
        n_checks++;
        if (fmask(4) !== 64'h100 || fmask(3) !== 64'h0) begin
            n_errors++; $display("FAIL nd_done_rx: got %h %h required 100 0", fmask(4), fmask(3));
        end
        n_checks++;
        if (g_obs[1].err !== 1'b0) begin n_errors++; $display("FAIL nd_err_cleared: got %b required 0", g_obs[1].err); end
    endtask

    task automatic test_reset_mid();
        sig_t e;
        run_xfer(1'b1, 16'h0404, $urandom(), 4, 0, 0, 0, $urandom(), $urandom(), 1'b0, 7);
        reset = 1'b1;
        wdata_valid = 1'b1;
        @(negedge clkin50);
        e = '0; e.csn = 1'b1;
        n_checks++;
        if (sample() !== e) begin
            n_errors++; $display("FAIL mid_reset_abort: got %h required %h", sample(), e);
        end
        @(posedge clkin50);
        #1;
        reset = 1'b0;
        wdata_valid = 1'b0;
        @(negedge clkin50);
        n_checks++;
        if (req_ready !== 1'b0 || cs_n !== 1'b1) begin
            n_errors++; $display("FAIL mid_reset_release: got rdy %b cs_n %b required 0 1", req_ready, cs_n);
        end
        @(negedge clkin50);
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset_ready: got rdy %b busy %b required 1 0", req_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        run_xfer(1'b0, 16'h0505, $urandom(), 2, 1, 0, 0, 32'h0, 32'h0, 1'b1, -1);
        run_xfer(1'b1, 16'h0606, $urandom(), 2, 0, -1, 1, $urandom(), $urandom(), 1'b1, -1);
        n_checks++;
        if (g_acc_cyc + 1 - g_prev_done !== CSH_CYC + 1) begin
            n_errors++; $display("FAIL b2b_latency_1: got %0d required %0d", g_acc_cyc + 1 - g_prev_done, CSH_CYC + 1);
        end
        run_xfer(1'b0, 16'h0707, $urandom(), 0, 2, 0, 0, 32'h0, 32'h0, 1'b0, -1);
        n_checks++;
        if (g_acc_cyc + 1 - g_prev_done !== CSH_CYC + 1) begin
            n_errors++; $display("FAIL b2b_latency_2: got %0d required %0d", g_acc_cyc + 1 - g_prev_done, CSH_CYC + 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            run_xfer(rbit(), 16'($urandom()), $urandom(), int'($urandom_range(5, 0)),
                     int'($urandom_range(6, 0)), -1, 2, $urandom(), $urandom(), 1'b0, -1);
        end
        run_xfer(1'b0, 16'($urandom()), $urandom(), 255, 31, 0, 0, 32'h0, 32'h0, 1'b0, -1);
        run_xfer(1'b1, 16'($urandom()), $urandom(), 255, 31, -1, 1, $urandom(), $urandom(), 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_dummy();
        test_underrun();
        test_read_nodata();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/opi_xfer_seq.md
Name: opi_xfer_seq

Overview:
- Transaction sequencer for the octal-SPI PHY transmit path.
- Accepts one transfer request and drives the 32b→8b gearbox strobe/lo16b/din interface through these phases in order: command, address, dummy, write data or read window.
- Owns chip-select, including the pipeline-drain tail and the minimum CS-high time.
- Sits between the memory-mapped OPI controller front end and the PHY gearbox, in the 50 MHz domain.

Parameters:
- LEN_W, 8, width of req_len (transfer length in 32-bit words).
- DUMMY_W, 5, width of req_dummy (dummy length in clkin50 cycles).
- TAIL_CYC, 3, cycles cs_n stays low after the final gap/read cycle, for gearbox drain; must be ≥2.
- CSH_CYC, 2, minimum cs_n-high cycles before the next request is accepted; must be ≥1.

Ports:
- clkin50 input 1: sole clock, 50 MHz gearbox-side clock.
- reset input 1: synchronous, active-high.
- req_valid input 1: request offered.
- req_ready output 1: request accepted when req_valid && req_ready.
- req_write input 1: 1 = write, 0 = read.
- req_cmd input 16: command word.
- req_addr input 32: address.
- req_len input LEN_W: data words; 0 = no data phase.
- req_dummy input DUMMY_W: dummy cycles.
- wdata_valid input 1: write word available.
- wdata input 32: write word.
- wdata_ready output 1: wdata consumed this cycle.
- phy_strobe output 1: load gearbox.
- phy_lo16b output 1: gearbox sends only phy_din[15:0].
- phy_din output 32: gearbox data; [15:0] is sent first.
- cs_n output 1: chip select, active-low.
- rx_en output 1: read capture window.
- busy output 1: state != IDLE.
- done output 1: one-cycle pulse at transfer end.
- err_underrun output 1: sticky write-underrun flag.

Behaviour:
- Reset values: req_ready=0 during reset, then 1 the cycle after reset deasserts; cs_n=1; all other outputs 0; state=IDLE.
- Reset mid-transfer: state returns to IDLE at the next edge and cs_n rises immediately. No tail or CSH sequence runs. err_underrun clears.
- req_ready = (state==IDLE). On accept, all req_* fields are latched and err_underrun clears.
- States: IDLE → CMD → GAP → ADDR → GAP → DUMMY (skipped if req_dummy=0) → WDATA or RDATA (skipped if len=0) → TAIL → CSH → IDLE.
- Every strobe state is followed by exactly one GAP cycle with phy_strobe=0. The gearbox needs 2 cycles per word, so strobes are never on consecutive cycles.
- CMD:
  - phy_strobe=1, phy_lo16b=1, phy_din={16'h0, cmd}.
  - cs_n falls in this cycle (combinational on state) and stays low through TAIL.
- ADDR:
  - phy_strobe=1, phy_lo16b=0, phy_din={addr[15:0], addr[31:16]}, so addr[31:16] goes out first.
- DUMMY: lasts req_dummy cycles; phy_strobe=0, phy_din=0.
- WDATA (write, len>0):
  - On each strobe slot, if wdata_valid: phy_strobe=1, phy_lo16b=0, phy_din=wdata, wdata_ready=1 (same cycle), then GAP.
  - Word counter decrements; after the GAP following the last word, go to TAIL.
  - If wdata_valid=0 in a slot: no strobe, stay in WDATA, set err_underrun (sticky until next accept or reset). Resume when data arrives.
- RDATA (read, len>0): rx_en=1 for exactly 2×len consecutive cycles; no strobes; then TAIL.
- Counter widths:
  - Read-window counter is LEN_W+1 bits.
  - len and dummy are unsigned; maximum values must work with no wrap: len=2^LEN_W−1 and dummy=2^DUMMY_W−1.
- TAIL: TAIL_CYC cycles, cs_n=0, phy_strobe=0.
- CSH:
  - CSH_CYC cycles with cs_n=1.
  - done=1 on the first CSH cycle only.
  - req_ready rises on the cycle after CSH ends.
- busy = (state != IDLE).
- wdata_ready is never asserted outside WDATA strobe slots.
- req_valid is ignored while busy; latched fields do not change mid-transfer.

Test Plan:
- Write, cmd=16'h12ED, addr=32'h0000_1000, len=2, dummy=0, wdata always valid (32'hAABBCCDD, 32'h11223344); accept at cycle 0:
  - strobes at cycles 1, 3, 5, 7; lo16b=1 only at cycle 1.
  - phy_din at cycle 3 = 32'h1000_0000.
  - wdata_ready at cycles 5 and 7.
  - cs_n low cycles 1–11; done at cycle 12; req_ready at cycle 14.
- Read, len=1, dummy=4: strobes at cycles 1 and 3; dummy cycles 5–8; rx_en at cycles 9–10; cs_n high at 14; done at 14.
- Write, len=1, wdata_valid held low for 3 slot cycles then high: no strobe during the stall; err_underrun=1 and stays set through done; clears on the next accept.
- Read, len=0, dummy=0: strobes at cycles 1 and 3; TAIL cycles 5–7; done at 8; rx_en never asserted.
- Assert reset during WDATA: cs_n=1 and phy_strobe=0 from the next edge; req_ready=1 one cycle after reset drops.
- req_valid held high continuously: back-to-back transfers are accepted exactly CSH_CYC+1 cycles after each done; no request is accepted while busy.
